// File: rtl/aes_inv_word_loader.sv
// Assembles 32-bit key/ciphertext words into 128-bit values for aes_inv_cipher_top,
// enforcing key-first ordering, the key-expansion wait, and one block in flight.
//
// state    | meaning
// COLLECT  | accepting words, s_ready high
// KEY_WAIT | key issued, waiting out the expansion window
// RUN      | block issued, waiting for done
module aes_inv_word_loader #(
    parameter int KEY_EXP_CYCLES = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_is_key,
    output logic         kld,
    output logic [127:0] key,
    output logic         ld,
    output logic [127:0] text_in,
    input  logic         done,
    output logic         key_valid,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        KEY_WAIT = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t         r_state;
    logic [95:0]    r_asm;
    logic [1:0]     r_cnt;
    logic           r_grp_key;
    logic [7:0]     r_wait;
    logic [127:0]   r_key;
    logic [127:0]   r_text;
    logic           r_kld;
    logic           r_ld;
    logic           r_err;
    logic           r_key_valid;
    logic           r_busy;

    logic           w_accept;
    logic           w_mismatch;
    logic           w_grp_key;
    logic [127:0]   w_full;

    assign s_ready    = (r_state == COLLECT) && !rst;
    assign w_accept   = s_valid && s_ready;
    assign w_mismatch = (r_cnt != 2'd0) && (s_is_key != r_grp_key);
    assign w_grp_key  = (r_cnt == 2'd0) ? s_is_key : r_grp_key;
    assign w_full     = {r_asm, s_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_asm       <= '0;
            r_cnt       <= '0;
            r_grp_key   <= 1'b0;
            r_wait      <= '0;
            r_key       <= '0;
            r_text      <= '0;
            r_kld       <= 1'b0;
            r_ld        <= 1'b0;
            r_err       <= 1'b0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_kld <= 1'b0;
            r_ld  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        r_asm <= {r_asm[63:0], s_data};
                        if (w_mismatch) begin
                            // Partial group dropped; this word opens a fresh group.
                            r_err     <= 1'b1;
                            r_grp_key <= s_is_key;
                            r_cnt     <= 2'd1;
                        end else begin
                            r_grp_key <= w_grp_key;
                            r_cnt     <= r_cnt + 2'd1;
                            if (r_cnt == 2'd3) begin
                                if (w_grp_key) begin
                                    r_key       <= w_full;
                                    r_kld       <= 1'b1;
                                    r_key_valid <= 1'b0;
                                    r_wait      <= 8'(KEY_EXP_CYCLES);
                                    r_state     <= KEY_WAIT;
                                end else if (r_key_valid) begin
                                    r_text  <= w_full;
                                    r_ld    <= 1'b1;
                                    r_busy  <= 1'b1;
                                    r_state <= RUN;
                                end else begin
                                    r_err <= 1'b1;
                                end
                            end
                        end
                    end
                end
                KEY_WAIT: begin
                    r_wait <= r_wait - 8'd1;
                    if (r_wait == 8'd1) begin
                        r_key_valid <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end
                RUN: begin
                    // done is not trusted in the ld cycle itself
                    if (done && !r_ld) begin
                        r_busy  <= 1'b0;
                        r_state <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign kld       = r_kld;
    assign key       = r_key;
    assign ld        = r_ld;
    assign text_in   = r_text;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_inv_word_loader.sv
// Scoreboard bench for aes_inv_word_loader: a group-level reference model queues
// expected kld/ld/err events; a negedge monitor pops and compares them.
module tb_aes_inv_word_loader;

    localparam int KEXP = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         s_is_key = 1'b0;
    logic         kld;
    logic [127:0] key;
    logic         ld;
    logic [127:0] text_in;
    logic         done = 1'b0;
    logic         key_valid;
    logic         busy;
    logic         err;

    aes_inv_word_loader #(.KEY_EXP_CYCLES(KEXP)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_is_key(s_is_key), .kld(kld), .key(key),
        .ld(ld), .text_in(text_in), .done(done), .key_valid(key_valid),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int           kind;   // 0 err, 1 kld, 2 ld
        int unsigned  when;
        logic [127:0] val;
    } ev_t;

    ev_t          exp_q[$];
    logic [31:0]  grp[$];
    logic         grp_key;
    logic         m_kv = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_ev(input int kind, input int unsigned when, input logic [127:0] v);
        ev_t e;
        e.kind = kind; e.when = when; e.val = v;
        exp_q.push_back(e);
    endfunction

    // Reference: words collect into a group; a type change aborts it.
    function automatic void model_accept(input logic [31:0] d, input logic k, input int unsigned when);
        logic [127:0] v;
        if (grp.size() != 0 && grp_key != k) begin
            push_ev(0, when, '0);
            grp.delete();
        end
        if (grp.size() == 0) grp_key = k;
        grp.push_back(d);
        if (grp.size() == 4) begin
            v = {grp[0], grp[1], grp[2], grp[3]};
            if (k) begin
                push_ev(1, when, v);
                m_kv = 1'b1;
            end else if (m_kv) begin
                push_ev(2, when, v);
            end else begin
                push_ev(0, when, '0);
            end
            grp.delete();
        end
    endfunction

    function automatic void mon_ev(input int kind, input logic [127:0] v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.when != cyc || e.val !== v) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d val %h expected kind %0d cyc %0d val %h",
                     kind, cyc, v, e.kind, e.when, e.val);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (err) mon_ev(0, '0);
            if (kld) mon_ev(1, key);
            if (ld) begin
                mon_ev(2, text_in);
                check("busy_at_ld", 128'(busy), 128'(1));
            end
        end
    end

    // Cipher stand-in: done returned 5 cycles after each ld.
    always @(negedge clk) begin
        if (ld && !rst) begin
            repeat (5) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            check("after_done_busy", 128'(busy), 128'(0));
            check("after_done_ready", 128'(s_ready), 128'(1));
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_word(input logic [31:0] d, input logic k);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_is_key = k;
        while (!s_ready) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                errors++; checks++;
                $display("FAIL accept_timeout: word %h not accepted, required within 300 cycles", d);
                s_valid = 1'b0;
                return;
            end
        end
        model_accept(d, k, cyc + 1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_group(input logic [127:0] v, input logic k);
        for (int i = 3; i >= 0; i--) send_word(v[i*32 +: 32], k);
    endtask

    task automatic key_load_timed(input logic [127:0] v);
        int low = 0;
        send_group(v, 1'b1);
        while (!s_ready && low < 400) begin
            low++;
            @(negedge clk);
        end
        check("key_window_len", 128'(low), 128'(KEXP));
        check("key_valid_after_window", 128'(key_valid), 128'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_kld"}, 128'(kld), 128'(0));
        check({tag, "_ld"}, 128'(ld), 128'(0));
        check({tag, "_err"}, 128'(err), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_key_valid"}, 128'(key_valid), 128'(0));
        check({tag, "_key"}, key, '0);
        check({tag, "_text_in"}, text_in, '0);
    endtask

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        logic [127:0] blk;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check("ready_in_reset", 128'(s_ready), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 128'(s_ready), 128'(1));

        // data with no key loaded: one err, no ld
        send_group(128'h11111111222222223333333344444444, 1'b0);
        check("ready_after_nokey", 128'(s_ready), 128'(1));

        key_load_timed(KEY0);
        send_group(CT0, 1'b0);
        repeat (8) @(negedge clk);

        // mismatch: two key words then a full data group
        send_word(32'hdead0001, 1'b1);
        send_word(32'hdead0002, 1'b1);
        send_group(128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3, 1'b0);

        // back-to-back blocks; words held during RUN must be refused
        send_group(128'h0123456789abcdef0011223344556677, 1'b0);
        s_valid = 1'b1; s_data = 32'hcafef00d; s_is_key = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ready_low_in_run", 128'(s_ready), 128'(0));
            @(negedge clk);
        end
        send_group(128'hcafef00d8899aabbccddeeff13572468, 1'b0);
        repeat (8) @(negedge clk);

        // reset while a block is in flight
        send_group(128'hfeedfacefeedfacefeedfacefeedface, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        check("ready_in_mid_reset", 128'(s_ready), 128'(0));
        rst = 1'b0;
        grp.delete();
        m_kv = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 128'(s_ready), 128'(1));
        repeat (8) @(negedge clk);
        check("busy_after_late_done", 128'(busy), 128'(0));
        check("ready_after_late_done", 128'(s_ready), 128'(1));

        // randomized mix of key and data words
        blk = {$urandom, $urandom, $urandom, $urandom};
        key_load_timed(blk);
        for (int i = 0; i < 80; i++) begin
            send_word($urandom, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
